day015_bytewise_dp_ram: RTL and testbench

Parametrised true dual-port RAM that generalises the day-14 two-port RAM. It adds per-port enables, byte write enables, configurable read latency (1 or 2 cycles) and a per-port read-valid strobe. It also defines read-during-write and same-address collision behaviour. It sits as the shared buffer between two independent masters on one clock domain.

---
 rtl/day015_bytewise_dp_ram.sv | 181 ++++++++++++++++++
 tb/tb_day015_bytewise_dp_ram.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/day015_bytewise_dp_ram.sv
`default_nettype none
// ============================================================================
// Module   : day015_bytewise_dp_ram
// Purpose  : True dual-port RAM shared by two masters on one clock. Each
//            port has its own enable, byte write enables and a read pipeline
//            of 1 or 2 cycles with a read-valid strobe.
//            Same-address writes on both ports merge byte by byte, with
//            port A taking priority.
// Ports    : clk_i, rst_n_i (async, active-low)
//            en/we/be/addr/data_in per port (A, B)
//            data_out_a_o/data_out_b_o - read data (held between accesses)
//            valid_a_o/valid_b_o       - one pulse per completed read
//            collision_o               - same-address access with a write
//            collision_cnt_o           - saturating collision count
// Options  : `DPRAM_COLLISION_EN enables the collision detector; without it
//            collision_o and collision_cnt_o are tied to 0.
// Revision : 1.0 - initial release
// ============================================================================
module day015_bytewise_dp_ram #(
  parameter  int DATA_WIDTH   = 32,
  parameter  int DEPTH        = 16,
  parameter  int READ_LATENCY = 1,
  parameter  int WRITE_FIRST  = 0,
  localparam int ADDR_WIDTH   = $clog2(DEPTH),
  localparam int NB           = DATA_WIDTH / 8
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  en_a_i,
  input  logic                  we_a_i,
  input  logic [NB-1:0]         be_a_i,
  input  logic [ADDR_WIDTH-1:0] addr_a_i,
  input  logic [DATA_WIDTH-1:0] data_in_a_i,
  input  logic                  en_b_i,
  input  logic                  we_b_i,
  input  logic [NB-1:0]         be_b_i,
  input  logic [ADDR_WIDTH-1:0] addr_b_i,
  input  logic [DATA_WIDTH-1:0] data_in_b_i,
  output logic [DATA_WIDTH-1:0] data_out_a_o,
  output logic [DATA_WIDTH-1:0] data_out_b_o,
  output logic                  valid_a_o,
  output logic                  valid_b_o,
  output logic                  collision_o,
  output logic [7:0]            collision_cnt_o
);

  // Storage is byte-organised so byte enables map to whole elements.
  logic [NB-1:0][7:0] mem_q [DEPTH];

  // Port signals gathered into arrays so both ports share one generate body.
  logic [1:0]                 w_en;
  logic [1:0]                 w_we;
  logic [1:0][NB-1:0]         w_be;
  logic [1:0][ADDR_WIDTH-1:0] w_addr;
  logic [1:0][DATA_WIDTH-1:0] w_din;
  logic [1:0][DATA_WIDTH-1:0] w_dout;
  logic [1:0]                 w_vld;

  assign w_en   = {en_b_i, en_a_i};
  assign w_we   = {we_b_i, we_a_i};
  assign w_be   = {be_b_i, be_a_i};
  assign w_addr = {addr_b_i, addr_a_i};
  assign w_din  = {data_in_b_i, data_in_a_i};

  // Port B is written first and port A second: when both hit the same byte,
  // A's later non-blocking update wins. Memory is not reset, but writes are
  // suppressed while reset is asserted so contents survive it.
  always_ff @(posedge clk_i) begin
    if (rst_n_i) begin
      for (int k = 0; k < NB; k++) begin
        if (en_b_i && we_b_i && be_b_i[k]) begin
          mem_q[addr_b_i][k] <= data_in_b_i[8*k +: 8];
        end
        if (en_a_i && we_a_i && be_a_i[k]) begin
          mem_q[addr_a_i][k] <= data_in_a_i[8*k +: 8];
        end
      end
    end
  end

  for (genvar p = 0; p < 2; p++) begin : g_port
    logic [DATA_WIDTH-1:0] w_old;
    logic [DATA_WIDTH-1:0] w_merged;
    logic [DATA_WIDTH-1:0] w_s1;
    logic [DATA_WIDTH-1:0] s1_data_q;
    logic                  s1_vld_q;

    // The array read reflects the word before this edge's writes, which is
    // what gives the other port old data on a cross-port collision.
    assign w_old = mem_q[w_addr[p]];

    always_comb begin
      w_merged = w_old;
      for (int k = 0; k < NB; k++) begin
        if (w_be[p][k]) begin
          w_merged[8*k +: 8] = w_din[p][8*k +: 8];
        end
      end
    end

    assign w_s1 = (w_we[p] && (WRITE_FIRST != 0)) ? w_merged : w_old;

    // Any access (read or write) refreshes the output; only reads flag valid.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
        s1_data_q <= '0;
        s1_vld_q  <= 1'b0;
      end else begin
        s1_vld_q <= w_en[p] & ~w_we[p];
        if (w_en[p]) begin
          s1_data_q <= w_s1;
        end
      end
    end

    if (READ_LATENCY == 2) begin : g_lat2
      logic                  s1_upd_q;
      logic [DATA_WIDTH-1:0] out_data_q;
      logic                  out_vld_q;

      always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
          s1_upd_q   <= 1'b0;
          out_data_q <= '0;
          out_vld_q  <= 1'b0;
        end else begin
          s1_upd_q  <= w_en[p];
          out_vld_q <= s1_vld_q;
          if (s1_upd_q) begin
            out_data_q <= s1_data_q;
          end
        end
      end

      assign w_dout[p] = out_data_q;
      assign w_vld[p]  = out_vld_q;
    end else begin : g_lat1
      assign w_dout[p] = s1_data_q;
      assign w_vld[p]  = s1_vld_q;
    end
  end

  assign data_out_a_o = w_dout[0];
  assign data_out_b_o = w_dout[1];
  assign valid_a_o    = w_vld[0];
  assign valid_b_o    = w_vld[1];

`ifdef DPRAM_COLLISION_EN
  logic       w_coll;
  logic       collision_q;
  logic [7:0] collision_cnt_q;
  logic [7:0] collision_cnt_d;

  assign w_coll = en_a_i & en_b_i & (addr_a_i == addr_b_i) & (we_a_i | we_b_i);

  always_comb begin
    collision_cnt_d = collision_cnt_q;
    if (w_coll && (collision_cnt_q != 8'hFF)) begin
      collision_cnt_d = collision_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      collision_q     <= 1'b0;
      collision_cnt_q <= 8'd0;
    end else begin
      collision_q     <= w_coll;
      collision_cnt_q <= collision_cnt_d;
    end
  end

  assign collision_o     = collision_q;
  assign collision_cnt_o = collision_cnt_q;
`else
  assign collision_o     = 1'b0;
  assign collision_cnt_o = 8'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_day015_bytewise_dp_ram.sv
`default_nettype none
// ============================================================================
// Module   : tb_day015_bytewise_dp_ram
// Purpose  : Self-checking bench. Instance u_l1 uses latency 1 and old-data
//            read-during-write; u_l2 uses latency 2 and new-data
//            read-during-write. Both instances get the same stimulus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_day015_bytewise_dp_ram;

`ifdef DPRAM_COLLISION_EN
  localparam bit COL_EN = 1'b1;
`else
  localparam bit COL_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ea, wa, eb, wb;
  logic [3:0]  ba, bb, aa, ab;
  logic [31:0] da, db;

  logic [31:0] o1a, o1b, o2a, o2b;
  logic        v1a, v1b, v2a, v2b, c1, c2;
  logic [7:0]  n1, n2;

  always #5 clk = ~clk;

  day015_bytewise_dp_ram #(.DATA_WIDTH(32), .DEPTH(16), .READ_LATENCY(1), .WRITE_FIRST(0)) u_l1 (
    .clk_i(clk), .rst_n_i(rst_n),
    .en_a_i(ea), .we_a_i(wa), .be_a_i(ba), .addr_a_i(aa), .data_in_a_i(da),
    .en_b_i(eb), .we_b_i(wb), .be_b_i(bb), .addr_b_i(ab), .data_in_b_i(db),
    .data_out_a_o(o1a), .data_out_b_o(o1b), .valid_a_o(v1a), .valid_b_o(v1b),
    .collision_o(c1), .collision_cnt_o(n1));

  day015_bytewise_dp_ram #(.DATA_WIDTH(32), .DEPTH(16), .READ_LATENCY(2), .WRITE_FIRST(1)) u_l2 (
    .clk_i(clk), .rst_n_i(rst_n),
    .en_a_i(ea), .we_a_i(wa), .be_a_i(ba), .addr_a_i(aa), .data_in_a_i(da),
    .en_b_i(eb), .we_b_i(wb), .be_b_i(bb), .addr_b_i(ab), .data_in_b_i(db),
    .data_out_a_o(o2a), .data_out_b_o(o2b), .valid_a_o(v2a), .valid_b_o(v2b),
    .collision_o(c2), .collision_cnt_o(n2));

  typedef struct {
    logic ea; logic wa; logic [3:0] ba; logic [3:0] aa; logic [31:0] da;
    logic eb; logic wb; logic [3:0] bb; logic [3:0] ab; logic [31:0] db;
    logic ca; logic [31:0] xa; logic va;
    logic cb; logic [31:0] xb; logic vb;
    logic col;
  } vec_t;

  vec_t        tbl [16];
  logic [31:0] mdl [16];
  logic [31:0] sbq [$];
  bit          sb_on = 1'b0;
  int          checks = 0;
  int          errors = 0;
  int          cnt_exp = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive both ports and update the reference memory (B first, A overrides).
  task automatic drive(input logic iea, input logic iwa, input logic [3:0] iba,
                       input logic [3:0] iaa, input logic [31:0] ida,
                       input logic ieb, input logic iwb, input logic [3:0] ibb,
                       input logic [3:0] iab, input logic [31:0] idb);
    ea = iea; wa = iwa; ba = iba; aa = iaa; da = ida;
    eb = ieb; wb = iwb; bb = ibb; ab = iab; db = idb;
    if (rst_n) begin
      for (int k = 0; k < 4; k++) begin
        if (ieb && iwb && ibb[k]) mdl[iab][8*k +: 8] = idb[8*k +: 8];
        if (iea && iwa && iba[k]) mdl[iaa][8*k +: 8] = ida[8*k +: 8];
      end
    end
  endtask

  task automatic idle();
    drive(0, 0, 4'h0, 4'h0, 32'h0, 0, 0, 4'h0, 4'h0, 32'h0);
  endtask

  task automatic wait_sb();
    int n = 0;
    while (sbq.size() != 0 && n < 10) begin
      tick();
      n++;
    end
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: got %0d pending expected 0", sbq.size());
    end
  endtask

  // Scoreboard for the latency-2 instance, port A.
  always @(posedge clk) begin
    #1;
    if (sb_on && v2a === 1'b1) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: got valid with data %h expected no read", o2a);
      end else begin
        chk("sb_data", o2a, sbq.pop_front());
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    // ea wa ba aa da | eb wb bb ab db | ca xa va | cb xb vb | col
    tbl[0]  = '{1,1,4'hF,4'd3,32'hA5A5A5A5, 1,1,4'hF,4'd5,32'h11223344, 0,32'h0,0, 0,32'h0,0, 0};
    tbl[1]  = '{1,1,4'hF,4'd2,32'h00000001, 1,1,4'hF,4'd7,32'h00000000, 0,32'h0,0, 0,32'h0,0, 0};
    tbl[2]  = '{0,0,4'h0,4'd0,32'h0,        1,0,4'h0,4'd3,32'h0, 0,32'h0,0, 1,32'hA5A5A5A5,1, 0};
    tbl[3]  = '{0,0,4'h0,4'd0,32'h0,        0,0,4'h0,4'd0,32'h0, 0,32'h0,0, 1,32'hA5A5A5A5,0, 0};
    tbl[4]  = '{1,1,4'h5,4'd5,32'hAABBCCDD, 0,0,4'h0,4'd0,32'h0, 1,32'h11223344,0, 1,32'hA5A5A5A5,0, 0};
    tbl[5]  = '{1,0,4'h0,4'd5,32'h0,        0,0,4'h0,4'd0,32'h0, 1,32'h11BB33DD,1, 1,32'hA5A5A5A5,0, 0};
    tbl[6]  = '{1,1,4'hF,4'd2,32'h00000002, 0,0,4'h0,4'd0,32'h0, 1,32'h00000001,0, 1,32'hA5A5A5A5,0, 0};
    tbl[7]  = '{1,0,4'h0,4'd2,32'h0,        1,1,4'h3,4'd2,32'h0000FFFF, 1,32'h00000002,1, 1,32'h00000002,0, 1};
    tbl[8]  = '{1,0,4'h0,4'd2,32'h0,        1,0,4'h0,4'd2,32'h0, 1,32'h0000FFFF,1, 1,32'h0000FFFF,1, 0};
    tbl[9]  = '{1,1,4'hC,4'd7,32'hFFFF0000, 1,1,4'h6,4'd7,32'h12345678, 1,32'h0,0, 1,32'h0,0, 1};
    tbl[10] = '{1,0,4'h0,4'd7,32'h0,        1,0,4'h0,4'd7,32'h0, 1,32'hFFFF5600,1, 1,32'hFFFF5600,1, 0};
    tbl[11] = '{0,1,4'hF,4'd7,32'hDEADBEEF, 1,0,4'h0,4'd3,32'h0, 1,32'hFFFF5600,0, 1,32'hA5A5A5A5,1, 0};
    tbl[12] = '{1,0,4'h0,4'd7,32'h0,        1,1,4'h0,4'd3,32'h0, 1,32'hFFFF5600,1, 1,32'hA5A5A5A5,0, 0};
    tbl[13] = '{1,0,4'h0,4'd3,32'h0,        0,0,4'h0,4'd0,32'h0, 1,32'hA5A5A5A5,1, 1,32'hA5A5A5A5,0, 0};
    tbl[14] = '{1,1,4'hF,4'd0,32'h10101010, 1,1,4'hF,4'd1,32'h20202020, 0,32'h0,0, 0,32'h0,0, 0};
    tbl[15] = '{0,0,4'h0,4'd0,32'h0,        0,0,4'h0,4'd0,32'h0, 0,32'h0,0, 0,32'h0,0, 0};

    // Reset state
    rst_n = 1'b0;
    idle();
    repeat (3) tick();
    chk("rst_l1_da", o1a, 32'h0);
    chk("rst_l1_db", o1b, 32'h0);
    chk("rst_l1_valid", {30'h0, v1a, v1b}, 32'h0);
    chk("rst_l2_da", o2a, 32'h0);
    chk("rst_l2_valid", {30'h0, v2a, v2b}, 32'h0);
    chk("rst_coll", {23'h0, c1, n1}, 32'h0);
    rst_n = 1'b1;
    tick();

    // Table-driven single-cycle vectors on the latency-1 instance
    for (int i = 0; i < 16; i++) begin
      drive(tbl[i].ea, tbl[i].wa, tbl[i].ba, tbl[i].aa, tbl[i].da,
            tbl[i].eb, tbl[i].wb, tbl[i].bb, tbl[i].ab, tbl[i].db);
      tick();
      if (tbl[i].col && COL_EN) cnt_exp++;
      chk($sformatf("vec%0d_va", i), {31'h0, v1a}, {31'h0, tbl[i].va});
      chk($sformatf("vec%0d_vb", i), {31'h0, v1b}, {31'h0, tbl[i].vb});
      if (tbl[i].ca) chk($sformatf("vec%0d_da", i), o1a, tbl[i].xa);
      if (tbl[i].cb) chk($sformatf("vec%0d_db", i), o1b, tbl[i].xb);
      chk($sformatf("vec%0d_col", i), {31'h0, c1}, {31'h0, tbl[i].col & COL_EN});
      chk($sformatf("vec%0d_cnt", i), {24'h0, n1}, cnt_exp);
      // Latency-2 / write-first instance shows the previous row's result.
      if (i == 5) chk("l2_wfirst_be", o2a, 32'h11BB33DD);
      if (i == 7) begin
        chk("l2_wfirst_rdw", o2a, 32'h00000002);
        chk("l2_wfirst_valid", {31'h0, v2a}, 32'h0);
      end
    end
    idle();
    repeat (3) tick();

    // Latency 2: three back-to-back reads on A
    sb_on = 1'b1;
    for (int j = 0; j < 5; j++) begin
      if (j < 3) begin
        drive(1, 0, 4'h0, j[3:0], 32'h0, 0, 0, 4'h0, 4'h0, 32'h0);
        sbq.push_back(mdl[j]);
      end else begin
        idle();
      end
      tick();
      chk($sformatf("l2_valid%0d", j), {31'h0, v2a}, {31'h0, (j >= 1 && j <= 3)});
      if (j >= 1 && j <= 3) chk($sformatf("l2_data%0d", j), o2a, mdl[j-1]);
    end
    wait_sb();

    // Reset in the middle of an in-flight read
    drive(1, 0, 4'h0, 4'd1, 32'h0, 0, 0, 4'h0, 4'h0, 32'h0);
    tick();
    rst_n = 1'b0;
    #1;
    chk("midrst_l2_va", {31'h0, v2a}, 32'h0);
    chk("midrst_l2_da", o2a, 32'h0);
    chk("midrst_l1_va", {31'h0, v1a}, 32'h0);
    chk("midrst_l1_da", o1a, 32'h0);
    idle();
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    chk("midrst_discard", {31'h0, v2a}, 32'h0);
    tick();
    chk("midrst_discard2", {31'h0, v2a}, 32'h0);

    // Contents retained through reset
    begin
      logic [3:0] ra [6];
      ra = '{4'd3, 4'd5, 4'd7, 4'd2, 4'd0, 4'd1};
      for (int j = 0; j < 6; j++) begin
        drive(1, 0, 4'h0, ra[j], 32'h0, 0, 0, 4'h0, 4'h0, 32'h0);
        sbq.push_back(mdl[ra[j]]);
        tick();
        chk($sformatf("keep%0d_valid", j), {31'h0, v1a}, 32'h1);
        chk($sformatf("keep%0d_data", j), o1a, mdl[ra[j]]);
      end
    end
    idle();
    wait_sb();
    sb_on = 1'b0;

    // Collision counter saturation
    for (int j = 0; j < 300; j++) begin
      drive(1, 1, 4'hF, 4'd9, j, 1, 0, 4'h0, 4'd9, 32'h0);
      tick();
      if (j == 0) begin
        chk("sat_first_col", {31'h0, c1}, {31'h0, COL_EN});
        chk("sat_first_cnt", {24'h0, n1}, {31'h0, COL_EN});
      end
    end
    idle();
    tick();
    chk("sat_l1_cnt", {24'h0, n1}, COL_EN ? 32'd255 : 32'd0);
    chk("sat_l2_cnt", {24'h0, n2}, COL_EN ? 32'd255 : 32'd0);
    chk("sat_col_drop", {30'h0, c1, c2}, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
